// File: rtl/rv32imf_pkg.sv
// Shared types for the RV32M divider: operation encoding and FSM state.
package rv32imf_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PREP   = 3'd1,
    DIVIDE = 3'd2,
    FIX    = 3'd3,
    DONE   = 3'd4
  } div_state_e;

endpackage

// File: rtl/rv32imf_ff_one.sv
// Find-first-one: index of the lowest set bit of in_i; no_ones_o flags an all-zero input.
module rv32imf_ff_one #(
  parameter int LEN = 32
) (
  input  logic [LEN-1:0]         in_i,
  output logic [$clog2(LEN)-1:0] first_one_o,
  output logic                   no_ones_o
);

  localparam int LW = $clog2(LEN);

  always_comb begin
    first_one_o = '0;
    no_ones_o   = (in_i == '0);
    // Scan downwards so the lowest set bit wins.
    for (int i = LEN - 1; i >= 0; i--) begin
      if (in_i[i]) first_one_o = LW'(i);
    end
  end

endmodule

// File: rtl/rv32imf_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU; the divisor is
// pre-aligned to the dividend so only quotient-width iterations are spent.
module rv32imf_div
  import rv32imf_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  div_op_e         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o
);

  // Handshake: an operation is taken on an edge with in_valid_i & in_ready_o;
  // the result is offered with out_valid_o and retired on an edge with
  // out_valid_o & out_ready_i. flush_i overrides both.

  div_state_e      r_state, w_next;
  div_op_e         r_op;
  logic [XLEN-1:0] r_a, r_b, r_rem, r_d, r_q;
  logic [5:0]      r_cnt;
  logic            r_sq, r_sr;

  logic            w_signed;
  logic [XLEN-1:0] w_abs_a, w_abs_b, w_rev_a, w_rev_b;
  logic [4:0]      w_lza, w_lzb, w_sh;
  logic            w_a_zero, w_b_zero, w_fast, w_accept;

  assign w_signed = (r_op == DIV) || (r_op == REM);
  assign w_abs_a  = (w_signed && r_a[XLEN-1]) ? (~r_a + 1'b1) : r_a;
  assign w_abs_b  = (w_signed && r_b[XLEN-1]) ? (~r_b + 1'b1) : r_b;

  always_comb begin
    w_rev_a = '0;
    w_rev_b = '0;
    for (int i = 0; i < XLEN; i++) begin
      w_rev_a[i] = w_abs_a[XLEN-1-i];
      w_rev_b[i] = w_abs_b[XLEN-1-i];
    end
  end

  rv32imf_ff_one #(.LEN(XLEN)) u_lz_a (
    .in_i        (w_rev_a),
    .first_one_o (w_lza),
    .no_ones_o   (w_a_zero)
  );

  rv32imf_ff_one #(.LEN(XLEN)) u_lz_b (
    .in_i        (w_rev_b),
    .first_one_o (w_lzb),
    .no_ones_o   (w_b_zero)
  );

  assign w_sh     = w_lzb - w_lza;
  assign w_fast   = w_b_zero || w_a_zero || (w_lzb < w_lza);
  assign w_accept = in_valid_i && (r_state == IDLE) && !flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) w_next = PREP;
      end
      PREP:    w_next = w_fast ? FIX : DIVIDE;
      DIVIDE:  if (r_cnt == '0) w_next = FIX;
      FIX:     w_next = DONE;
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (flush_i) w_next = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op     <= DIV;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_d      <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_sq     <= 1'b0;
      r_sr     <= 1'b0;
      result_o <= '0;
    end else if (!flush_i) begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_op <= op_i;
          r_a  <= a_i;
          r_b  <= b_i;
        end
        PREP: begin
          r_q <= '0;
          if (w_fast) begin
            // Trivial results bypass sign correction: r is the raw dividend.
            r_rem <= r_a;
            r_sq  <= 1'b0;
            r_sr  <= 1'b0;
            if (w_b_zero) r_q <= '1;
          end else begin
            r_rem <= w_abs_a;
            r_d   <= w_abs_b << w_sh;
            r_cnt <= {1'b0, w_sh} + 6'd1;
            r_sq  <= (r_op == DIV) && (r_a[XLEN-1] ^ r_b[XLEN-1]);
            r_sr  <= (r_op == REM) && r_a[XLEN-1];
          end
        end
        DIVIDE: if (r_cnt != '0) begin
          if (r_rem >= r_d) begin
            r_rem <= r_rem - r_d;
            r_q   <= {r_q[XLEN-2:0], 1'b1};
          end else begin
            r_q   <= {r_q[XLEN-2:0], 1'b0};
          end
          r_d   <= r_d >> 1;
          r_cnt <= r_cnt - 6'd1;
        end
        FIX: begin
          if ((r_op == DIV) || (r_op == DIVU))
            result_o <= r_sq ? (~r_q + 1'b1) : r_q;
          else
            result_o <= r_sr ? (~r_rem + 1'b1) : r_rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32imf_div.sv
// Directed-vector bench for rv32imf_div: results, latencies, hold, flush and reset abort.
module tb_rv32imf_div;
  import rv32imf_pkg::*;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  div_op_e     op;
  logic [31:0] a, b, result;

  int n_vec = 0;
  int n_err = 0;

  rv32imf_div dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_i        (op),
    .a_i         (a),
    .b_i         (b),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one request; returns after the accept edge (+1 time unit).
  task automatic start_op(input div_op_e o, input logic [31:0] av, input logic [31:0] bv);
    op = o; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h1234_5678;
  endtask

  // Edges counted after the accept edge until out_valid is seen (bounded).
  task automatic run_op(input div_op_e o, input logic [31:0] av, input logic [31:0] bv,
                        output logic [31:0] res, output int lat);
    start_op(o, av, bv);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0) begin
      n_err++;
      $display("FAIL reset: in_ready=%b out_valid=%b result=%h, required 1 0 00000000",
               in_ready, out_valid, result);
    end
  endtask

  task automatic test_divu_basic();
    logic [31:0] res; int lat;
    run_op(DIVU, 32'd100, 32'd7, res, lat);
    n_vec++;
    if (res !== 32'd14) begin n_err++; $display("FAIL divu_100_7: got %h, required %h", res, 32'd14); end
    n_vec++;
    if (lat !== 8) begin n_err++; $display("FAIL divu_100_7_latency: got %0d, required 8", lat); end
    consume();
    run_op(DIVU, 32'd9, 32'd3, res, lat);
    n_vec++;
    if (res !== 32'd3 || lat !== 6) begin
      n_err++; $display("FAIL divu_9_3: got %h lat %0d, required 00000003 lat 6", res, lat);
    end
    consume();
  endtask

  task automatic test_signed();
    logic [31:0] res; int lat;
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, res, lat);
    n_vec++;
    if (res !== 32'hFFFF_FFFD || lat !== 5) begin
      n_err++; $display("FAIL div_m7_2: got %h lat %0d, required fffffffd lat 5", res, lat);
    end
    consume();
    run_op(REM, 32'hFFFF_FFF9, 32'd2, res, lat);
    n_vec++;
    if (res !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rem_m7_2: got %h, required ffffffff", res); end
    consume();
    run_op(DIV, 32'd20, 32'hFFFF_FFFB, res, lat);
    n_vec++;
    if (res !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL div_20_m5: got %h, required fffffffc", res); end
    consume();
    run_op(REMU, 32'd100, 32'd7, res, lat);
    n_vec++;
    if (res !== 32'd2) begin n_err++; $display("FAIL remu_100_7: got %h, required 00000002", res); end
    consume();
  endtask

  task automatic test_overflow();
    logic [31:0] res; int lat;
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    n_vec++;
    if (res !== 32'h8000_0000) begin n_err++; $display("FAIL div_ovf: got %h, required 80000000", res); end
    n_vec++;
    if (lat !== 35) begin n_err++; $display("FAIL div_ovf_latency: got %0d, required 35", lat); end
    consume();
    run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    n_vec++;
    if (res !== 32'h0) begin n_err++; $display("FAIL rem_ovf: got %h, required 00000000", res); end
    consume();
  endtask

  task automatic test_div_by_zero();
    logic [31:0] res; int lat;
    run_op(DIVU, 32'd5, 32'd0, res, lat);
    n_vec++;
    if (res !== 32'hFFFF_FFFF || lat !== 2) begin
      n_err++; $display("FAIL divu_by_zero: got %h lat %0d, required ffffffff lat 2", res, lat);
    end
    consume();
    run_op(REM, 32'hFFFF_FFFB, 32'd0, res, lat);
    n_vec++;
    if (res !== 32'hFFFF_FFFB || lat !== 2) begin
      n_err++; $display("FAIL rem_by_zero: got %h lat %0d, required fffffffb lat 2", res, lat);
    end
    consume();
    run_op(DIV, 32'd0, 32'hFFFF_FFF9, res, lat);
    n_vec++;
    if (res !== 32'h0 || lat !== 2) begin
      n_err++; $display("FAIL div_zero_dividend: got %h lat %0d, required 00000000 lat 2", res, lat);
    end
    consume();
  endtask

  task automatic test_hold_reaccept();
    logic [31:0] res; int lat;
    run_op(REMU, 32'd3, 32'd10, res, lat);
    n_vec++;
    if (res !== 32'd3 || lat !== 2) begin
      n_err++; $display("FAIL remu_3_10: got %h lat %0d, required 00000003 lat 2", res, lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd3) begin
        n_err++;
        $display("FAIL hold_%0d: out_valid=%b in_ready=%b result=%h, required 1 0 00000003",
                 i, out_valid, in_ready, result);
      end
    end
    consume();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    run_op(DIVU, 32'd9, 32'd3, res, lat);
    n_vec++;
    if (res !== 32'd3) begin n_err++; $display("FAIL reaccept: got %h, required 00000003", res); end
    consume();
  endtask

  // kill_with_reset=0 uses flush_i, 1 uses an rst_ni pulse, in DIVIDE cycle 3.
  task automatic test_abort(input bit kill_with_reset);
    logic [31:0] res; int lat; bit seen;
    start_op(DIVU, 32'hFFFF_FFFF, 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    if (kill_with_reset) rst_n = 1'b0;
    else flush = 1'b1;
    if (kill_with_reset) begin
      #1;
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0) begin
        n_err++;
        $display("FAIL reset_abort: in_ready=%b out_valid=%b result=%h, required 1 0 00000000",
                 in_ready, out_valid, result);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
      flush = 1'b0;
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd3) begin
        n_err++;
        $display("FAIL flush: in_ready=%b out_valid=%b result=%h, required 1 0 00000003",
                 in_ready, out_valid, result);
      end
    end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    n_vec++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL abort_no_result: out_valid seen=%b, required 0", seen); end
    run_op(DIVU, 32'd9, 32'd3, res, lat);
    n_vec++;
    if (res !== 32'd3 || lat !== 6) begin
      n_err++; $display("FAIL after_abort: got %h lat %0d, required 00000003 lat 6", res, lat);
    end
    consume();
  endtask

  task automatic test_flush_idle_drop();
    op = DIVU; a = 32'd8; b = 32'd2; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_drop: in_ready=%b, required 1", in_ready); end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = DIV; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_divu_basic();
    test_signed();
    test_overflow();
    test_div_by_zero();
    test_hold_reaccept();
    test_abort(1'b0);
    test_abort(1'b1);
    test_flush_idle_drop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
